// File: rtl/toaplan2_snd_mixn.sv
// toaplan2_snd_mixn: sequential N-channel gain mixer with saturation and optional gain slew
module toaplan2_snd_mixn #(
  parameter int NCH  = 4,
  parameter int W    = 16,
  parameter int WOUT = 16,
  parameter int RAMP = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   cen,
  input  logic [NCH*W-1:0]       ch_in,
  input  logic [NCH*8-1:0]       gain_in,
  input  logic                   mute,
  output logic signed [WOUT-1:0] mixed,
  output logic                   sample,
  output logic                   peak,
  output logic                   overrun
);
  localparam int AW = W + 9 + $clog2(NCH);
  localparam int IW = $clog2(NCH);
  localparam int SW = AW + WOUT;
  localparam logic signed [SW-1:0] S_MAX = SW'((64'sd1 <<< (WOUT - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] S_MIN = ~S_MAX;

  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [W-1:0] ch_q [NCH];
  logic [7:0] tgt_q [NCH];
  logic [7:0] g_cur_q [NCH];
  logic signed [W+8:0] prod;
  logic signed [SW-1:0] s, s_sat;
  logic last, latch;

  assign latch = (state_q == IDLE) && cen;
  assign last  = idx_q == IW'(NCH - 1);
  assign prod  = (W+9)'(ch_q[idx_q]) * (W+9)'($signed({1'b0, g_cur_q[idx_q]}));
  assign acc_d = acc_q + AW'(prod);
  // Scaling and clamping happen on the final accumulate so mixed is valid while sample is high
  assign s     = SW'(acc_d >>> 4);
  assign s_sat = s > S_MAX ? S_MAX : s < S_MIN ? S_MIN : s;

  always_ff @(posedge CLK)
    state_q <= RESET ? IDLE : state_d;

  always_comb
    state_d = state_q == IDLE ? (cen ? ACC : IDLE) : state_q == ACC ? (last ? SAT : ACC) : IDLE;

  always_comb begin
    sample  = state_q == SAT;
    overrun = cen && (state_q != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_q <= '0;
      acc_q <= '0;
      mixed <= '0;
      peak  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        ch_q[i]    <= '0;
        tgt_q[i]   <= '0;
        g_cur_q[i] <= '0;
      end
    end else begin
      if (latch) begin
        acc_q <= '0;
        idx_q <= '0;
        for (int i = 0; i < NCH; i++) begin
          ch_q[i]  <= ch_in[i*W +: W];
          tgt_q[i] <= mute ? 8'd0 : gain_in[i*8 +: 8];
          if (RAMP == 0) g_cur_q[i] <= mute ? 8'd0 : gain_in[i*8 +: 8];
        end
      end
      if (state_q == ACC) begin
        acc_q <= acc_d;
        idx_q <= idx_q + IW'(1);
        if (last) begin
          mixed <= s_sat[WOUT-1:0];
          peak  <= (s > S_MAX) || (s < S_MIN);
        end
      end
      if (state_q == SAT && RAMP != 0)
        for (int i = 0; i < NCH; i++)
          g_cur_q[i] <= g_cur_q[i] < tgt_q[i] ? g_cur_q[i] + 8'd1 :
                        g_cur_q[i] > tgt_q[i] ? g_cur_q[i] - 8'd1 : g_cur_q[i];
    end
  end
endmodule

// File: tb/tb_toaplan2_snd_mixn.sv
// tb_toaplan2_snd_mixn: directed vectors on a 3-channel immediate-gain mixer and a 4-channel ramped mixer
module tb_toaplan2_snd_mixn;
  logic clk = 0;
  always #5 clk = ~clk;

  logic rst3, cen3, mute3, smp3, pk3, ovr3;
  logic [47:0] ch3;
  logic [23:0] gn3;
  logic signed [15:0] m3;
  logic rst4, cen4, mute4, smp4, pk4, ovr4;
  logic [63:0] ch4;
  logic [31:0] gn4;
  logic signed [15:0] m4;

  toaplan2_snd_mixn #(.NCH(3), .W(16), .WOUT(16), .RAMP(0)) u3 (
    .CLK(clk), .RESET(rst3), .cen(cen3), .ch_in(ch3), .gain_in(gn3), .mute(mute3),
    .mixed(m3), .sample(smp3), .peak(pk3), .overrun(ovr3));
  toaplan2_snd_mixn #(.NCH(4), .W(16), .WOUT(16), .RAMP(1)) u4 (
    .CLK(clk), .RESET(rst4), .cen(cen4), .ch_in(ch4), .gain_in(gn4), .mute(mute4),
    .mixed(m4), .sample(smp4), .peak(pk4), .overrun(ovr4));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int c0, c1, c2, g0, g1, g2;
    bit mute;
    int exp_m;
    bit exp_p;
  } vec_t;

  function automatic int model3(input int c0, c1, c2, g0, g1, g2, input bit m, output bit p);
    longint sum, sh;
    sum = m ? 0 : longint'(c0) * g0 + longint'(c1) * g1 + longint'(c2) * g2;
    sh = sum >>> 4;
    p = (sh > 32767) || (sh < -32768);
    return sh > 32767 ? 32767 : sh < -32768 ? -32768 : int'(sh);
  endfunction

  task automatic run3(input vec_t v, input string nm);
    int k;
    @(negedge clk);
    ch3 = {v.c2[15:0], v.c1[15:0], v.c0[15:0]};
    gn3 = {v.g2[7:0], v.g1[7:0], v.g0[7:0]};
    mute3 = v.mute;
    cen3 = 1;
    @(negedge clk);
    cen3 = 0;
    mute3 = !v.mute;
    ch3 = ~ch3;
    k = 1;
    while (!smp3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({nm, " latency"}, k, 4);
    check({nm, " mixed"}, int'(m3), v.exp_m);
    check({nm, " peak"}, pk3, v.exp_p);
  endtask

  task automatic run4(input int c0, input int g0, input bit m, input int em, input string nm);
    int k;
    @(negedge clk);
    ch4 = {48'd0, c0[15:0]};
    gn4 = {24'd0, g0[7:0]};
    mute4 = m;
    cen4 = 1;
    @(negedge clk);
    cen4 = 0;
    k = 1;
    while (!smp4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({nm, " latency"}, k, 5);
    check({nm, " mixed"}, int'(m4), em);
  endtask

  vec_t tbl[12];

  initial begin
    int first, cnt, c0, c1, c2, g0, g1, g2;
    bit m, p;
    vec_t rv;
    tbl[0]  = '{1000, -500, 0, 16, 8, 16, 0, 750, 0};
    tbl[1]  = '{30000, 0, 0, 32, 0, 0, 0, 32767, 1};
    tbl[2]  = '{-30000, 0, 0, 32, 0, 0, 0, -32768, 1};
    tbl[3]  = '{100, 0, 0, 16, 0, 0, 0, 100, 0};
    tbl[4]  = '{1000, 2000, 3000, 16, 16, 16, 1, 0, 0};
    tbl[5]  = '{32767, 32767, 32767, 255, 255, 255, 0, 32767, 1};
    tbl[6]  = '{-32768, -32768, -32768, 255, 255, 255, 0, -32768, 1};
    tbl[7]  = '{-1, 0, 0, 1, 0, 0, 0, -1, 0};
    tbl[8]  = '{7, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{32767, 0, 0, 16, 0, 0, 0, 32767, 0};
    tbl[10] = '{32767, 1, 0, 16, 16, 0, 0, 32767, 1};
    tbl[11] = '{-32768, 0, 0, 16, 0, 0, 0, -32768, 0};

    rst3 = 1; rst4 = 1; cen3 = 0; cen4 = 0; mute3 = 0; mute4 = 0;
    ch3 = '0; gn3 = '0; ch4 = '0; gn4 = '0;
    repeat (3) @(negedge clk);
    check("reset mixed3", int'(m3), 0);
    check("reset sample3", smp3, 0);
    check("reset peak3", pk3, 0);
    check("reset mixed4", int'(m4), 0);
    check("reset overrun4", ovr4, 0);
    rst3 = 0; rst4 = 0;

    for (int i = 0; i < 12; i++) run3(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 30; i++) begin
      c0 = $urandom_range(65535) - 32768; c1 = $urandom_range(65535) - 32768;
      c2 = $urandom_range(65535) - 32768;
      g0 = $urandom_range(255); g1 = $urandom_range(255); g2 = $urandom_range(255);
      m = ($urandom_range(7) == 0);
      rv = '{c0, c1, c2, g0, g1, g2, m, 0, 0};
      rv.exp_m = model3(c0, c1, c2, g0, g1, g2, m, p);
      rv.exp_p = p;
      run3(rv, $sformatf("rnd%0d", i));
    end

    for (int k = 0; k < 20; k++) run4(160, 16, 0, (k < 16 ? k : 16) * 10, $sformatf("ramp_up%0d", k));

    @(negedge clk);
    ch4 = {48'd0, 16'd320}; gn4 = {24'd0, 8'h10}; mute4 = 0; cen4 = 1;
    #1 check("ovr idle", ovr4, 0);
    @(negedge clk); cen4 = 0;
    @(negedge clk); ch4 = {48'd0, 16'd1000}; cen4 = 1;
    #1 check("ovr busy", ovr4, 1);
    @(negedge clk); cen4 = 0;
    #1 check("ovr drop", ovr4, 0);
    first = -1; cnt = 0;
    for (int k = 3; k <= 15; k++) begin
      if (k > 3) @(negedge clk);
      #1;
      if (smp4) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    check("ovr sample count", cnt, 1);
    check("ovr sample cycle", first, 5);
    check("ovr mixed", int'(m4), 320);

    @(negedge clk);
    ch4 = {48'd0, 16'd500}; cen4 = 1;
    @(negedge clk); cen4 = 0;
    @(negedge clk); rst4 = 1;
    @(negedge clk); rst4 = 0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (smp4) cnt++;
    end
    check("rst abort samples", cnt, 0);
    check("rst mixed", int'(m4), 0);
    check("rst peak", pk4, 0);

    for (int k = 0; k <= 16; k++) run4(160, 16, 0, k * 10, $sformatf("reramp%0d", k));
    for (int k = 0; k <= 16; k++) run4(160, 16, 1, (16 - k) * 10, $sformatf("mute%0d", k));
    run4(160, 16, 1, 0, "mute_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
